// File: rtl/nios_timer_pkg.sv
// Shared constants for the interval-timer scheduler: timer register map,
// control word bits, scheduler FSM state encodings and the bus-write record.
package nios_timer_pkg;

  localparam logic [2:0] TMR_ADDR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_ADDR_PERIOD_H = 3'd3;

  localparam logic [15:0] CTRL_ITO   = 16'h0001;
  localparam logic [15:0] CTRL_CONT  = 16'h0002;
  localparam logic [15:0] CTRL_START = 16'h0004;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  // One-shot start: interrupt enabled, continuous mode explicitly cleared.
  localparam logic [15:0] CTRL_ONESHOT = (CTRL_START | CTRL_ITO) & ~CTRL_CONT;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR_PL    = 3'd1;
  localparam logic [2:0] ST_WR_PH    = 3'd2;
  localparam logic [2:0] ST_WR_CTL   = 3'd3;
  localparam logic [2:0] ST_WAIT_IRQ = 3'd4;
  localparam logic [2:0] ST_WR_STOP  = 3'd5;
  localparam logic [2:0] ST_CLR_ST   = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } tmr_wr_t;

endpackage

// File: rtl/nios_rr_arbiter.sv
// Combinational round-robin arbiter: picks the lowest requesting index at or
// after ptr, wrapping at NUM_REQ.
module nios_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               valid
);

  localparam logic [ID_W:0] N_W = (ID_W+1)'(NUM_REQ);

  always_comb begin
    logic [ID_W:0] sum;
    sum   = '0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      if (!valid && req[sum[ID_W-1:0]]) begin
        grant[sum[ID_W-1:0]] = 1'b1;
        idx                  = sum[ID_W-1:0];
        valid                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nios_timer_scheduler.sv
// Shares one interval timer among NUM_REQ one-shot delay requesters: arbitrates,
// programs the timer, waits for irq, clears timeout and pulses done.
module nios_timer_scheduler
  import nios_timer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] delay,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic                  tmr_irq
);

  // Requester handshake: req is a level held until the one-cycle done pulse;
  // dropping req before done cancels the delay and no done is returned.

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [2:0]         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [31:0]        load_q, load_d;
  logic               cancel_q, cancel_d;
  logic               cs_q, cs_d;
  logic               wn_q;
  tmr_wr_t            wr_q, wr_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_valid;
  logic [31:0]        sel_delay;
  logic [31:0]        sel_m1;
  logic [NUM_REQ-1:0] grant_oh;
  logic               req_g;

  nios_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_delay = '0;
    grant_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_delay = delay[i*32 +: 32];
      grant_oh[i] = (grant_id_q == ID_W'(i));
    end
    sel_m1 = sel_delay - 32'd1;
    req_g  = |(req & grant_oh);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    done_d     = '0;
    load_d     = load_q;
    cancel_d   = cancel_q;
    cs_d       = 1'b0;
    wr_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_id_d = arb_idx;
          ptr_d      = (arb_idx == LAST_ID) ? '0 : arb_idx + 1'b1;
          busy_d     = 1'b1;
          cancel_d   = 1'b0;
          load_d     = sel_m1;
          // A zero delay never touches the timer.
          if (sel_delay == '0) begin
            state_d = ST_DONE;
            done_d  = arb_grant;
          end else begin
            state_d = ST_WR_PL;
            cs_d    = 1'b1;
            wr_d    = '{addr: TMR_ADDR_PERIOD_L, data: sel_m1[15:0]};
          end
        end
      end
      ST_WR_PL: begin
        state_d = ST_WR_PH;
        cs_d    = 1'b1;
        wr_d    = '{addr: TMR_ADDR_PERIOD_H, data: load_q[31:16]};
      end
      ST_WR_PH: begin
        state_d = ST_WR_CTL;
        cs_d    = 1'b1;
        wr_d    = '{addr: TMR_ADDR_CONTROL, data: CTRL_ONESHOT};
      end
      ST_WR_CTL: state_d = ST_WAIT_IRQ;
      ST_WAIT_IRQ: begin
        // Cancel wins over a coincident irq.
        if (!req_g) begin
          state_d  = ST_WR_STOP;
          cancel_d = 1'b1;
          cs_d     = 1'b1;
          wr_d     = '{addr: TMR_ADDR_CONTROL, data: CTRL_STOP};
        end else if (tmr_irq) begin
          state_d = ST_CLR_ST;
          cs_d    = 1'b1;
          wr_d    = '{addr: TMR_ADDR_STATUS, data: 16'h0000};
        end
      end
      ST_WR_STOP: begin
        state_d = ST_CLR_ST;
        cs_d    = 1'b1;
        wr_d    = '{addr: TMR_ADDR_STATUS, data: 16'h0000};
      end
      ST_CLR_ST: begin
        if (cancel_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
          done_d  = grant_oh;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= '0;
      load_q     <= '0;
      cancel_q   <= 1'b0;
      cs_q       <= 1'b0;
      wn_q       <= 1'b1;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_q     <= load_d;
      cancel_q   <= cancel_d;
      cs_q       <= cs_d;
      wn_q       <= ~cs_d;
      wr_q       <= wr_d;
    end
  end

  assign done           = done_q;
  assign busy           = busy_q;
  assign grant_id       = grant_id_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_address    = wr_q.addr;
  assign tmr_writedata  = wr_q.data;

endmodule

// File: tb/tb_nios_timer_scheduler.sv
// Bench for nios_timer_scheduler: cycle table for a full transaction, then
// directed sequences for arbitration order, zero/large delays, cancel and reset.
module tb_nios_timer_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] delay;
  logic [3:0]   done;
  logic         busy;
  logic [1:0]   grant_id;
  logic [2:0]   tmr_address;
  logic         tmr_chipselect;
  logic         tmr_write_n;
  logic [15:0]  tmr_writedata;
  logic         tmr_irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [18:0] exp_q[$];
  logic [3:0]  exp_done_q[$];

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        irq;
    logic        exp_cs;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
    logic [3:0]  exp_done;
    logic        exp_busy;
    logic [1:0]  exp_gid;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  nios_timer_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .delay          (delay),
    .done           (done),
    .busy           (busy),
    .grant_id       (grant_id),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_delay(input int i, input logic [31:0] v);
    delay[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    tmr_irq = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: every bus write and every done pulse must match the next expected item.
  always @(negedge clk) begin
    if (tmr_chipselect === 1'b1 || tmr_write_n === 1'b0) begin
      check("strobe_pair", {tmr_chipselect, tmr_write_n}, 2'b10);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%04h expected none", tmr_address, tmr_writedata);
      end else begin
        check("bus_write", {tmr_address, tmr_writedata}, exp_q.pop_front());
      end
    end
    if (done !== 4'b0000) begin
      if (exp_done_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got 0x%0h expected none", done);
      end else begin
        check("done_pulse", done, exp_done_q.pop_front());
      end
    end
  end

  task automatic wait_grant(input logic [1:0] gid);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) break;
    end
    check("grant_busy", busy, 1'b1);
    check("grant_id", grant_id, gid);
  endtask

  task automatic wait_write(input logic [2:0] addr);
    for (int i = 0; i < 20; i++) begin
      if (tmr_chipselect === 1'b1 && tmr_address === addr) break;
      tick();
    end
    check("wait_write", {tmr_chipselect, tmr_address}, {1'b1, addr});
  endtask

  task automatic run_txn(input logic [1:0] gid, input logic [31:0] dly, input int irq_wait);
    logic [31:0] l;
    logic [3:0]  oh;
    l  = dly - 32'd1;
    oh = 4'b0001 << gid;
    exp_q.push_back({3'd2, l[15:0]});
    exp_q.push_back({3'd3, l[31:16]});
    exp_q.push_back({3'd1, 16'h0005});
    exp_q.push_back({3'd0, 16'h0000});
    exp_done_q.push_back(oh);
    wait_grant(gid);
    wait_write(3'd1);
    for (int i = 0; i < irq_wait; i++) tick();
    tmr_irq = 1'b1;
    wait_write(3'd0);
    tmr_irq = 1'b0;
    tick();
    check("txn_done", done, oh);
    req[gid] = 1'b0;
    tick();
    check("txn_idle", {busy, done}, 5'b0);
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    tmr_irq = 1'b0;
    delay   = '0;

    // Test 1: cycle table, req[1] with delay 100, including reset and idle irq.
    set_delay(1, 32'd100);
    vecs[0] = '{1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0000, 4'h0, 1'b0, 2'd0};
    vecs[1] = '{1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 16'h0000, 4'h0, 1'b0, 2'd0};
    vecs[2] = '{1'b0, 4'h2, 1'b0, 1'b1, 3'd2, 16'h0063, 4'h0, 1'b1, 2'd1};
    vecs[3] = '{1'b0, 4'h2, 1'b0, 1'b1, 3'd3, 16'h0000, 4'h0, 1'b1, 2'd1};
    vecs[4] = '{1'b0, 4'h2, 1'b0, 1'b1, 3'd1, 16'h0005, 4'h0, 1'b1, 2'd1};
    vecs[5] = '{1'b0, 4'h2, 1'b0, 1'b0, 3'd0, 16'h0000, 4'h0, 1'b1, 2'd1};
    vecs[6] = '{1'b0, 4'h2, 1'b0, 1'b0, 3'd0, 16'h0000, 4'h0, 1'b1, 2'd1};
    vecs[7] = '{1'b0, 4'h2, 1'b1, 1'b1, 3'd0, 16'h0000, 4'h0, 1'b1, 2'd1};
    vecs[8] = '{1'b0, 4'h2, 1'b1, 1'b0, 3'd0, 16'h0000, 4'h2, 1'b1, 2'd1};
    vecs[9] = '{1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0000, 4'h0, 1'b0, 2'd1};
    for (int r = 0; r < 10; r++) begin
      reset   = vecs[r].rst;
      req     = vecs[r].req;
      tmr_irq = vecs[r].irq;
      if (vecs[r].exp_cs) exp_q.push_back({vecs[r].exp_addr, vecs[r].exp_data});
      if (vecs[r].exp_done != 4'h0) exp_done_q.push_back(vecs[r].exp_done);
      tick();
      check($sformatf("vec%0d_ctl", r), {tmr_chipselect, tmr_write_n, done, busy, grant_id},
            {vecs[r].exp_cs, ~vecs[r].exp_cs, vecs[r].exp_done, vecs[r].exp_busy, vecs[r].exp_gid});
      if (vecs[r].exp_cs)
        check($sformatf("vec%0d_bus", r), {tmr_address, tmr_writedata}, {vecs[r].exp_addr, vecs[r].exp_data});
    end

    // Test 2: round-robin order 0, 2, then 3 before 0.
    do_reset();
    for (int i = 0; i < 4; i++) set_delay(i, 32'd5);
    req = 4'b0101;
    run_txn(2'd0, 32'd5, 2);
    run_txn(2'd2, 32'd5, 1);
    req = 4'b1001;
    run_txn(2'd3, 32'd5, 1);
    run_txn(2'd0, 32'd5, 3);

    // Test 3: 0x10000 delay crosses the half-word boundary; zero delay skips the timer.
    do_reset();
    set_delay(1, 32'h0001_0000);
    req = 4'b0010;
    run_txn(2'd1, 32'h0001_0000, 1);
    set_delay(0, 32'd0);
    req = 4'b0001;
    exp_done_q.push_back(4'b0001);
    wait_grant(2'd0);
    check("zero_done", {tmr_chipselect, done}, 5'b0_0001);
    req = 4'b0000;
    tick();
    check("zero_idle", {busy, done}, 5'b0);

    // Test 4: drop req[2] in WAIT_IRQ, pending req[0] served afterwards.
    do_reset();
    for (int i = 0; i < 4; i++) set_delay(i, 32'd5);
    req = 4'b0100;
    exp_q.push_back({3'd2, 16'h0004});
    exp_q.push_back({3'd3, 16'h0000});
    exp_q.push_back({3'd1, 16'h0005});
    exp_q.push_back({3'd1, 16'h0008});
    exp_q.push_back({3'd0, 16'h0000});
    wait_grant(2'd2);
    req[0] = 1'b1;
    wait_write(3'd1);
    tick();
    tick();
    req[2] = 1'b0;
    wait_write(3'd1);
    check("stop_data", tmr_writedata, 16'h0008);
    wait_write(3'd0);
    tick();
    check("cancel_idle", {busy, done}, 5'b0);
    run_txn(2'd0, 32'd5, 1);

    // Test 5: req drop coincident with irq takes the cancel path.
    do_reset();
    req = 4'b0010;
    exp_q.push_back({3'd2, 16'h0004});
    exp_q.push_back({3'd3, 16'h0000});
    exp_q.push_back({3'd1, 16'h0005});
    exp_q.push_back({3'd1, 16'h0008});
    exp_q.push_back({3'd0, 16'h0000});
    wait_grant(2'd1);
    wait_write(3'd1);
    tick();
    req[1]  = 1'b0;
    tmr_irq = 1'b1;
    wait_write(3'd1);
    check("coinc_stop", tmr_writedata, 16'h0008);
    wait_write(3'd0);
    tmr_irq = 1'b0;
    tick();
    check("coinc_idle", {busy, done}, 5'b0);

    // Test 6: reset during WR_PH, pending req re-granted after release.
    do_reset();
    req = 4'b1000;
    exp_q.push_back({3'd2, 16'h0004});
    exp_q.push_back({3'd3, 16'h0000});
    wait_grant(2'd3);
    tick();
    check("ph_write", {tmr_chipselect, tmr_address}, {1'b1, 3'd3});
    reset = 1'b1;
    tick();
    check("rst_outputs", {tmr_chipselect, tmr_write_n, busy, grant_id, done, tmr_address, tmr_writedata},
          {1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 3'd0, 16'h0000});
    reset = 1'b0;
    run_txn(2'd3, 32'd5, 2);

    tick();
    check("exp_q_empty", exp_q.size(), 0);
    check("exp_done_q_empty", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
